// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a host-written note list into the tone generator,
// inserting rests and inter-note gaps and re-arming tone between notes.
module melody_sequencer #(
    parameter int CLK_F = 48,
    parameter int DEPTH = 64,
    parameter int GAP_MS = 10,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic          tone_done,
    output logic [31:0]   duration,
    output logic [31:0]   freq,
    output logic          busy,
    output logic [AW-1:0] note_idx,
    output logic          finished
);
    localparam int TICK = CLK_F * 1000;
    localparam int CW = $clog2(TICK);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, REST, GAP} state_t;
    state_t state;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data;
    logic [CW-1:0] cyc;
    logic [15:0] ms, rest_len;
    logic tick_end, rest_end, gap_end, wrap;
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[note_idx];
    end
    assign tick_end = cyc == CW'(TICK - 1);
    assign rest_end = tick_end && ms == rest_len - 16'd1;
    assign gap_end = GAP_MS == 0 || (tick_end && ms == 16'(GAP_MS - 1));
    assign wrap = loop && note_idx != '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            duration <= '0;
            freq <= '0;
            note_idx <= '0;
            finished <= 1'b0;
            cyc <= '0;
            ms <= '0;
            rest_len <= '0;
        end else begin
            finished <= 1'b0;
            cyc <= tick_end ? '0 : cyc + 1'b1;
            if (tick_end) ms <= ms + 16'd1;
            if (stop) begin
                state <= IDLE;
                duration <= '0;
                freq <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        note_idx <= '0;
                        state <= FETCH;
                    end
                    FETCH: state <= DECODE;
                    DECODE: if (rd_data[15:0] == '0) begin
                        if (wrap) begin
                            note_idx <= '0;
                            state <= FETCH;
                        end else begin
                            finished <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (rd_data[31:16] == '0) begin
                        cyc <= '0;
                        ms <= '0;
                        rest_len <= rd_data[15:0];
                        state <= REST;
                    end else begin
                        duration <= {16'd0, rd_data[15:0]};
                        freq <= {16'd0, rd_data[31:16]};
                        state <= PLAY;
                    end
                    PLAY: if (tone_done) begin
                        duration <= '0;
                        freq <= '0;
                        cyc <= '0;
                        ms <= '0;
                        state <= GAP;
                    end
                    REST: if (rest_end) begin
                        cyc <= '0;
                        ms <= '0;
                        state <= GAP;
                    end
                    GAP: if (gap_end) begin
                        if (note_idx != AW'(DEPTH - 1)) begin
                            note_idx <= note_idx + 1'b1;
                            state <= FETCH;
                        end else if (wrap) begin
                            note_idx <= '0;
                            state <= FETCH;
                        end else begin
                            finished <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: scoreboard bench; an entry-level playback model predicts
// each tone, finish and stop event with its lead time in silent busy cycles.
module tb_melody_sequencer;
    localparam int T = 1000;
    typedef struct {
        int kind;
        int idx;
        int d;
        int f;
        int z;
    } ev_t;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop_r = 1'b0, tone_done = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] dur [2];
    logic [31:0] frq [2];
    logic busy [2];
    logic fin [2];
    logic [2:0] idx [2];
    logic [31:0] mref [8];
    ev_t q [$];
    ev_t me;
    int sel = 0, kh = 5, n_chk = 0, n_pass = 0;
    int zc = 0, hold = 0, rc = 0;
    logic [31:0] pdur = '0, cur_d = '0, cur_f = '0;
    logic pbusy = 1'b0, ptd = 1'b0, in_rst = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int AWL = g ? 2 : 3;
        logic [AWL-1:0] ni;
        melody_sequencer #(.CLK_F(1), .DEPTH(g ? 4 : 8), .GAP_MS(g ? 2 : 0)) dut (
            .clk(clk),
            .resetn(resetn),
            .wr_en(wr_en && sel == g),
            .wr_addr(wr_addr[AWL-1:0]),
            .wr_data(wr_data),
            .start(start && sel == g),
            .stop(stop),
            .loop(loop_r),
            .tone_done(tone_done),
            .duration(dur[g]),
            .freq(frq[g]),
            .busy(busy[g]),
            .note_idx(ni),
            .finished(fin[g])
        );
        assign idx[g] = 3'(ni);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic push(input int kind, input int i, input int d, input int f, input int z);
        ev_t e;
        e = '{kind, i, d, f, z};
        q.push_back(e);
    endtask

    // Walks the note list entry by entry; kind 0 tone, 1 finished, 2 stopped.
    // mode at the cap-th tone: 1 stop, 2 drop loop, 3 async reset.
    task automatic model(input int g, input bit lp0, input int cap, input int mode, output int npost);
        int depth, gz, i, z, ev, capped, d, f;
        bit lp;
        depth = g ? 4 : 8;
        gz = g ? 2 * T : 1;
        i = 0; z = 0; ev = 0; capped = 0; lp = lp0; npost = 0;
        for (int n = 0; n < 200; n++) begin
            d = int'(mref[i][15:0]);
            f = int'(mref[i][31:16]);
            z += 2;
            if (d == 0) begin
                if (lp && i != 0) begin
                    i = 0;
                    continue;
                end
                push(1, i, 0, 0, z);
                npost += capped;
                return;
            end
            if (f == 0) z += d * T + gz;
            else begin
                push(0, i, d, f, z);
                npost += capped;
                z = gz;
                ev++;
                if (ev == cap) begin
                    capped = 1;
                    if (mode == 1) begin
                        push(2, i, 0, 0, 0);
                        npost = 1;
                        return;
                    end
                    if (mode == 3) return;
                    lp = 1'b0;
                end
            end
            if (i == depth - 1) begin
                if (!lp) begin
                    push(1, i, 0, 0, z);
                    npost += capped;
                    return;
                end
                i = 0;
            end else i++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        rc = (dur[sel] != 0) ? rc + 1 : 0;
        tone_done = (dur[sel] != 0) ? (rc == kh) : ($urandom_range(0, 3) == 0);
    end

    always @(negedge clk) begin
        if (!resetn) begin
            if (!in_rst) begin
                chk("reset duration", dur[sel], 0);
                chk("reset freq", frq[sel], 0);
                chk("reset busy", 32'(busy[sel]), 0);
                chk("reset note_idx", 32'(idx[sel]), 0);
                chk("reset finished", 32'(fin[sel]), 0);
            end
            in_rst = 1'b1;
        end else begin
            in_rst = 1'b0;
            if (!pbusy) zc = 0;
            if (ptd && pdur != 0) begin
                chk("drop after done", dur[sel], 0);
                chk("hold cycles", hold, kh);
            end
            if (dur[sel] != 0 && pdur == 0) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious tone: idx %0d dur %0d freq %0d, expected no event", idx[sel], dur[sel], frq[sel]);
                end else begin
                    me = q.pop_front();
                    chk("tone kind", 0, me.kind);
                    chk("tone note_idx", 32'(idx[sel]), me.idx);
                    chk("tone lead cycles", zc, me.z);
                    cur_d = me.d;
                    cur_f = me.f;
                end
                zc = 0;
                hold = 0;
            end
            if (dur[sel] != 0) begin
                hold++;
                chk("duration", dur[sel], cur_d);
                chk("freq", frq[sel], cur_f);
            end
            if (busy[sel] && dur[sel] == 0) zc++;
            if ((pbusy && !busy[sel]) || fin[sel]) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious end: finished %0d busy %0d, expected no event", fin[sel], busy[sel]);
                end else begin
                    me = q.pop_front();
                    chk("end kind", fin[sel] ? 1 : 2, me.kind);
                    chk("end note_idx", 32'(idx[sel]), me.idx);
                    chk("end busy", 32'(busy[sel]), 0);
                    chk("end duration", dur[sel], 0);
                    chk("end freq", frq[sel], 0);
                    if (me.kind == 1) chk("end lead cycles", zc, me.z);
                end
                zc = 0;
            end
        end
        pbusy = resetn && busy[sel];
        pdur = dur[sel];
        ptd = tone_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q(input int n);
        int c;
        c = 0;
        while (q.size() > n) begin
            @(negedge clk);
            c++;
            if (c > 40000) begin
                $display("FAIL timeout: %0d events outstanding, expected %0d", q.size(), n);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic run(input int g, input bit lp, input int cap, input int mode);
        int npost;
        sel = g;
        kh = $urandom_range(5, 9);
        loop_r = lp;
        for (int i = 0; i < (g ? 4 : 8); i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = mref[i];
            step();
        end
        wr_en = 1'b0;
        model(g, lp, cap, mode, npost);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_q(npost);
        if (mode == 1) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
        end else if (mode == 2) loop_r = 1'b0;
        else if (mode == 3) begin
            @(posedge clk);
            #2 resetn = 1'b0;
            repeat (3) @(negedge clk);
            step();
            resetn = 1'b1;
        end
        wait_q(0);
        repeat (3) step();
    endtask

    task automatic clr();
        for (int i = 0; i < 8; i++) mref[i] = '0;
    endtask

    task automatic tones();
        for (int i = 0; i < 8; i++) mref[i] = {16'(100 + 37 * i), 16'(i + 1)};
    endtask

    task automatic gen(input bit rests);
        int len;
        len = $urandom_range(0, 8);
        for (int i = 0; i < 8; i++)
            mref[i] = (i >= len) ? {16'($urandom), 16'd0}
                    : (rests && $urandom_range(0, 7) == 0) ? {16'd0, 16'($urandom_range(1, 2))}
                    : {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
    endtask

    initial begin
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        step();
        resetn = 1'b1;
        clr();
        mref[0] = {16'd440, 16'd2};
        mref[1] = {16'd880, 16'd1};
        run(0, 1'b0, 100, 0);
        mref[1] = {16'd0, 16'd3};
        mref[2] = {16'd880, 16'd1};
        run(0, 1'b0, 100, 0);
        clr();
        mref[0] = {16'd440, 16'd2};
        mref[1] = {16'd880, 16'd1};
        run(0, 1'b1, 5, 2);
        run(0, 1'b1, 4, 1);
        clr();
        mref[0] = {16'd123, 16'd0};
        run(0, 1'b0, 100, 0);
        run(0, 1'b1, 100, 0);
        tones();
        mref[3] = '0;
        run(0, 1'b0, 2, 1);
        run(0, 1'b0, 100, 0);
        tones();
        run(0, 1'b0, 100, 0);
        run(0, 1'b1, 10, 1);
        repeat (8) begin
            bit lp;
            int mode;
            lp = 1'($urandom_range(0, 1));
            gen(!lp);
            if (lp) mref[0] = {16'd1000, 16'd5};
            mode = lp ? $urandom_range(1, 2) : $urandom_range(0, 1);
            run(0, lp, $urandom_range(2, 6), mode);
        end
        tones();
        run(1, 1'b0, 100, 0);
        run(1, 1'b1, 5, 2);
        run(1, 1'b0, 1, 3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
